// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scan driver with per-frame input snapshot and registered outputs.
// Optional macro SEG7_DIM_EN adds a 3-bit brightness input (PWM within each lit slot).
module seg7_scan_mux #(
   parameter int NUM_DIGITS   = 6,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
`ifdef SEG7_DIM_EN
   input  logic [2:0]              bright_i,
`endif
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   digit_sel_o,
   output logic                    frame_o
);

   // Counter is at least 3 bits wide so the low bits can drive the dimming compare.
   localparam int CW = ($clog2(SCAN_DIV) < 3) ? 3 : $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d;
   logic                    frame_q, frame_d;
`ifdef SEG7_DIM_EN
   logic [2:0]              bright_q, bright_d;
`endif

   logic [3:0] nibble;
   logic       dp_bit;
   logic       lit;
   logic [6:0] seg_dec;

   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      snap_dig_d = snap_dig_q;
      snap_dp_d  = snap_dp_q;
      frame_d    = 1'b0;
`ifdef SEG7_DIM_EN
      bright_d   = bright_q;
`endif

      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // Frame cycle 0: capture inputs so every slot of this frame shows one coherent value.
      if (cnt_q == '0 && idx_q == '0) begin
         frame_d    = 1'b1;
         snap_dig_d = digits_i;
         snap_dp_d  = dp_i;
`ifdef SEG7_DIM_EN
         bright_d   = bright_i;
`endif
      end
   end

   always_comb begin
      nibble = 4'h0;
      dp_bit = 1'b0;
      sel_d  = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            nibble   = snap_dig_q[4*k +: 4];
            dp_bit   = snap_dp_q[k];
            sel_d[k] = 1'b1;
         end
      end

      case (nibble)
         4'd0:    seg_dec = 7'b0111111;
         4'd1:    seg_dec = 7'b0000110;
         4'd2:    seg_dec = 7'b1011011;
         4'd3:    seg_dec = 7'b1001111;
         4'd4:    seg_dec = 7'b1100110;
         4'd5:    seg_dec = 7'b1101101;
         4'd6:    seg_dec = 7'b1111101;
         4'd7:    seg_dec = 7'b0000111;
         4'd8:    seg_dec = 7'b1111111;
         4'd9:    seg_dec = 7'b1101111;
         default: seg_dec = 7'b0000000;
      endcase

      lit = (cnt_q >= BLANK);
`ifdef SEG7_DIM_EN
      // (count mod 8) < bright+1  <=>  count[2:0] <= bright
      lit = lit && (cnt_q[2:0] <= bright_q);
`endif

      if (lit) begin
         seg_d = seg_dec;
         dp_d  = dp_bit;
      end else begin
         seg_d = '0;
         dp_d  = 1'b0;
         sel_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         seg_q      <= '0;
         dp_q       <= 1'b0;
         sel_q      <= '0;
         frame_q    <= 1'b0;
`ifdef SEG7_DIM_EN
         bright_q   <= '0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         snap_dig_q <= snap_dig_d;
         snap_dp_q  <= snap_dp_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         sel_q      <= sel_d;
         frame_q    <= frame_d;
`ifdef SEG7_DIM_EN
         bright_q   <= bright_d;
`endif
      end
   end

   assign seg_o       = seg_q;
   assign dp_o        = dp_q;
   assign digit_sel_o = sel_q;
   assign frame_o     = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed and random checks of seg7_scan_mux with NUM_DIGITS=6, SCAN_DIV=4, BLANK_CYCLES=1.
module tb_seg7_scan_mux;

   localparam int ND = 6;
   localparam int SD = 4;
   localparam int BC = 1;

   logic          clk_i;
   logic          rst_i;
   logic [4*ND-1:0] digits_i;
   logic [ND-1:0] dp_i;
   logic [6:0]    seg_o;
   logic          dp_o;
   logic [ND-1:0] digit_sel_o;
   logic          frame_o;
`ifdef SEG7_DIM_EN
   logic [2:0]    bright_i;
`endif

   int vectors;
   int miscompares;

   seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .digits_i    (digits_i),
      .dp_i        (dp_i),
`ifdef SEG7_DIM_EN
      .bright_i    (bright_i),
`endif
      .seg_o       (seg_o),
      .dp_o        (dp_o),
      .digit_sel_o (digit_sel_o),
      .frame_o     (frame_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Checks n visible frame cycles starting at frame cycle 0 (called #1 after the edge
   // that raises frame_o). Optionally changes inputs at cycle chg_at.
   task automatic run_frame(input string name, input logic [4*ND-1:0] exp_d,
                            input logic [ND-1:0] exp_p, input int chg_at,
                            input logic [4*ND-1:0] nd, input logic [ND-1:0] np,
                            input int n);
      logic [15:0] got, exp;
      logic [6:0]  eseg;
      logic [ND-1:0] esel;
      logic        edp;
      int slot, cnt;
      for (int c = 0; c < n; c++) begin
         if (c == chg_at) begin
            digits_i = nd;
            dp_i     = np;
         end
         slot = c / SD;
         cnt  = c % SD;
         if (cnt < BC) begin
            eseg = '0; esel = '0; edp = 1'b0;
         end else begin
            eseg = seg_of(exp_d[4*slot +: 4]);
            esel = ND'(1) << slot;
            edp  = exp_p[slot];
         end
         exp = {1'b0, (c == 0), esel, eseg, edp};
         got = {1'b0, frame_o, digit_sel_o, seg_o, dp_o};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got frame=%b sel=%b seg=%b dp=%b, required frame=%b sel=%b seg=%b dp=%b",
                     name, c, frame_o, digit_sel_o, seg_o, dp_o, (c == 0), esel, eseg, edp);
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic check_dark(input string name);
      vectors++;
      if ({frame_o, digit_sel_o, seg_o, dp_o} !== '0) begin
         miscompares++;
         $display("FAIL %s: got frame=%b sel=%b seg=%b dp=%b, required all zero",
                  name, frame_o, digit_sel_o, seg_o, dp_o);
      end
   endtask

   task automatic test_reset();
      #2 rst_i = 1'b1;
      #1 check_dark("reset_async");
      repeat (3) @(posedge clk_i);
      #1 check_dark("reset_held");
      @(negedge clk_i) rst_i = 1'b0;
      #1 check_dark("reset_release_pre_edge");
      @(posedge clk_i); #1;
   endtask

   task automatic test_scan_and_no_tear();
      run_frame("scan_123456", 24'h123456, 6'b0, 10, 24'h999999, 6'b0, 24);
      run_frame("all_nines", 24'h999999, 6'b0, 5, 24'h12345A, 6'b000001, 24);
   endtask

   task automatic test_blank_digit();
      run_frame("nibble_A_dp", 24'h12345A, 6'b000001, -1, '0, '0, 24);
   endtask

   task automatic test_reset_midslot();
      run_frame("pre_reset", 24'h12345A, 6'b000001, -1, '0, '0, 14);
      #2 rst_i = 1'b1;
      #1 check_dark("midslot_async_clear");
      digits_i = 24'h024680;
      dp_i     = 6'b100000;
      repeat (2) @(posedge clk_i);
      #1 check_dark("midslot_held");
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i); #1;
      run_frame("post_reset", 24'h024680, 6'b100000, -1, '0, '0, 24);
   endtask

   task automatic test_random();
      logic [4*ND-1:0] cur_d, nxt_d;
      logic [ND-1:0]   cur_p, nxt_p;
      cur_d = 24'h024680;
      cur_p = 6'b100000;
      for (int f = 0; f < 1000; f++) begin
         nxt_d = 24'($urandom);
         nxt_p = 6'($urandom);
         run_frame("random", cur_d, cur_p, 1 + (f % 22), nxt_d, nxt_p, 24);
         cur_d = nxt_d;
         cur_p = nxt_p;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_i       = 1'b0;
      digits_i    = 24'h123456;
      dp_i        = '0;
`ifdef SEG7_DIM_EN
      bright_i    = 3'd7;
`endif
      test_reset();
      test_scan_and_no_tear();
      test_blank_digit();
      test_reset_midslot();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
